alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//   Shares one combinational 32-bit ALU (4-bit op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR,
//   6 SLL, 7 SRL, 8 SRA, 9 SLT) between NREQ requesters, e.g. execute stage and branch unit.
//   Round-robin grant feeds a 2-stage valid/ready pipeline: issue register drives the ALU,
//   result register returns ALU output with the requester ID.
// PARAMETERS
//   NREQ   2   number of requesters, 2..4
//   IDW    2   width of rsp_id, >= clog2(NREQ)
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        reset, asynchronous, active-high
//   req_valid  in   NREQ     request i valid
//   req_ready  out  NREQ     request i accepted this cycle when valid & ready
//   req_op     in   4*NREQ   op of requester i, bits [4i+3:4i]
//   req_a      in   32*NREQ  operand A of requester i (shamt = A[4:0] for shifts)
//   req_b      in   32*NREQ  operand B of requester i
//   alu_op     out  4        to shared ALU, from issue register
//   alu_a      out  32       to shared ALU
//   alu_b      out  32       to shared ALU
//   alu_out    in   32       combinational result of shared ALU
//   rsp_valid  out  1        result register holds valid data
//   rsp_ready  in   1        consumer takes result when valid & ready
//   rsp_id     out  IDW      requester index of the result
//   rsp_data   out  32       ALU result
// BEHAVIOUR
//   Reset (async, rst=1): all outputs 0; s1_valid=0, s2_valid=0, rr_ptr=0.
//   Stage S1 (issue reg: op,a,b,id,s1_valid) drives alu_op/alu_a/alu_b directly; S1 empty
//     -> alu_op/alu_a/alu_b forced to 0. Stage S2 (result reg) drives rsp_*.
//   Advance rules, evaluated per cycle:
//     s2_free  = !s2_valid | rsp_ready
//     s1_move  = s1_valid & s2_free          (S2 <= {s1_id, alu_out}, s2_valid <= 1)
//     s1_free  = !s1_valid | s1_move
//     accept   = s1_free & |req_valid        (S1 <= granted request, s1_valid <= 1)
//     S2 cleared (s2_valid<=0) when rsp_ready & s2_valid & !s1_move.
//     S1 cleared when s1_move & !accept.
//   Grant: combinational round-robin; first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ...
//     mod NREQ. req_ready = onehot(grant) & {NREQ{s1_free}}; at most one bit set; 0 when
//     no request valid. On accept rr_ptr <= (grant+1) mod NREQ; otherwise unchanged.
//   Latency: accept at edge N -> ALU sees operands during cycle N+1 -> rsp_valid=1 after
//     edge N+1 (cycle N+2 view). Full throughput 1 op/cycle with rsp_ready held 1.
//   Backpressure: rsp_valid & !rsp_ready holds rsp_id/rsp_data stable; S1 holds and keeps
//     driving ALU; req_ready all 0 while both stages full. No result dropped or duplicated.
//   Requester obligations: req_op/a/b stable while req_valid & !req_ready; arbiter does not
//     check. Ops 10..15 pass through; ALU returns 0 for them.
//   Fairness: any continuously-valid requester granted within NREQ accepts.
//   Reset mid-operation: both stages' contents discarded, no response for in-flight ops.
//   Results return in acceptance order (in-order pipe, no reordering).
// TESTING
//   Reset: rst=1 with req_valid=all 1 -> req_ready=0, rsp_valid=0, alu_op/a/b=0, rr_ptr=0.
//   Single op: req0 ADD a=5 b=7 -> req_ready[0]=1 at edge N; rsp_valid=1, rsp_id=0,
//     rsp_data=12 after edge N+1.
//   Round robin: req0 and req1 both always valid, rsp_ready=1 -> grants 0,1,0,1...;
//     req0 SUB 10-3, req1 SLT a=-1 b=1 -> rsp_data 7 (id0), 1 (id1) alternating.
//   Backpressure: rsp_ready=0 for 5 cycles with req0 streaming -> exactly 2 accepted,
//     rsp_data stable; release -> remaining results in order, none lost.
//   Shift op via shared ALU: req1 SRA a=4 b=0x80000000 -> rsp_data=0xF8000000, rsp_id=1.
//   Reset mid-flight: rst pulse with S1 and S2 full -> rsp_valid=0 next cycle, rr_ptr=0,
//     subsequent req0 ADD 1+1 returns 2 with normal 2-cycle latency.

Source files
------------

// File: rtl/alu_rr_arbiter_if.sv
// Bundle between the round-robin ALU arbiter, its requesters, the shared ALU and the result consumer.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
// and a requester holds op/a/b stable while valid && !ready.
interface alu_rr_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [3:0]         alu_op;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [31:0]        alu_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_out, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters through a
// two-stage in-order pipe: S1 issues operands to the ALU, S2 holds the result plus requester id.
module alu_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  alu_rr_arbiter_if.slave bus,
  output logic [IDW-1:0]  rr_ptr
);
  logic           s1_valid;
  logic [3:0]     s1_op;
  logic [31:0]    s1_a;
  logic [31:0]    s1_b;
  logic [IDW-1:0] s1_id;
  logic           s2_valid;
  logic [IDW-1:0] s2_id;
  logic [31:0]    s2_data;

  logic           s2_free;
  logic           s1_move;
  logic           s1_free;
  logic           accept;
  logic           grant_found;
  int             grant_idx;
  int             scan_idx;
  logic [3:0]     sel_op;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] next_ptr;

  assign s2_free = !s2_valid || bus.rsp_ready;
  assign s1_move = s1_valid && s2_free;
  assign s1_free = !s1_valid || s1_move;
  // Gated by rst so nothing looks accepted while the pipe is being flushed.
  assign accept  = s1_free && grant_found && !rst;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && (i == scan_idx) && bus.req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = i;
        end
      end
    end
  end

  always_comb begin
    sel_op        = '0;
    sel_a         = '0;
    sel_b         = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == grant_idx) begin
        sel_op           = bus.req_op[4*i +: 4];
        sel_a            = bus.req_a[32*i +: 32];
        sel_b            = bus.req_b[32*i +: 32];
        bus.req_ready[i] = accept;
      end
    end
  end

  assign grant_id = IDW'(grant_idx);
  assign next_ptr = (grant_idx == NREQ - 1) ? '0 : IDW'(grant_idx + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_data  <= '0;
      rr_ptr   <= '0;
    end else begin
      if (s1_move) begin
        s2_valid <= 1'b1;
        s2_id    <= s1_id;
        s2_data  <= bus.alu_out;
      end else if (bus.rsp_ready && s2_valid) begin
        s2_valid <= 1'b0;
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= sel_op;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_id    <= grant_id;
        rr_ptr   <= next_ptr;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // An empty issue stage presents zeros so the shared ALU sees no stale operands.
  assign bus.alu_op    = s1_valid ? s1_op : 4'd0;
  assign bus.alu_a     = s1_valid ? s1_a  : 32'd0;
  assign bus.alu_b     = s1_valid ? s1_b  : 32'd0;
  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_data  = s2_data;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: stands in for the shared ALU and checks every cycle against an
// occupancy-queue model of the pipe plus directed scenarios with known answers.
module tb_alu_rr_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 2;

  typedef struct packed {
    logic           fresh;
    logic [IDW-1:0] id;
    logic [3:0]     op;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [31:0]    res;
  } ent_t;
  localparam int EW = $bits(ent_t);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IDW-1:0] rr_ptr;

  alu_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rr_ptr (rr_ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return b << a[4:0];
      4'd7:    return b >> a[4:0];
      4'd8:    return sb >>> a[4:0];
      4'd9:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_out = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  // Scoreboard: in-flight ops in acceptance order; fresh = accepted on the last edge (still in S1).
  logic [EW-1:0] exp_q[$];
  int            mptr = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = v ? (bus.req_valid | NREQ'(1 << i)) : (bus.req_valid & ~NREQ'(1 << i));
    bus.req_op[4*i +: 4]   = op;
    bus.req_a[32*i +: 32]  = a;
    bus.req_b[32*i +: 32]  = b;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(output logic [NREQ-1:0] acc);
    int              g;
    int              idx;
    logic            found;
    logic            can;
    logic            exp_rv;
    logic [NREQ-1:0] exp_ready;
    ent_t            e;
    ent_t            s1e;
    logic            s1_full;
    #1;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (!found && (((bus.req_valid >> idx) & 1) != 0)) begin
        found = 1'b1;
        g     = idx;
      end
    end
    can       = (exp_q.size() < 2) || bus.rsp_ready;
    exp_ready = (found && can) ? NREQ'(1 << g) : '0;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("rr_ptr", 32'(rr_ptr), 32'(mptr));

    exp_rv = 1'b0;
    if (exp_q.size() > 0) begin
      e      = ent_t'(exp_q[0]);
      exp_rv = !(exp_q.size() == 1 && e.fresh);
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
      check("rsp_data", bus.rsp_data, e.res);
    end

    s1_full = 1'b0;
    s1e     = '0;
    if (exp_q.size() == 2) begin
      s1e     = ent_t'(exp_q[1]);
      s1_full = 1'b1;
    end else if (exp_q.size() == 1 && e.fresh) begin
      s1e     = e;
      s1_full = 1'b1;
    end
    check("alu_op", 32'(bus.alu_op), s1_full ? 32'(s1e.op) : 32'd0);
    check("alu_a", bus.alu_a, s1_full ? s1e.a : 32'd0);
    check("alu_b", bus.alu_b, s1_full ? s1e.b : 32'd0);

    @(posedge clk);
    if (exp_rv && bus.rsp_ready) void'(exp_q.pop_front());
    for (int i = 0; i < exp_q.size(); i++) begin
      e          = ent_t'(exp_q[i]);
      e.fresh    = 1'b0;
      exp_q[i]   = EW'(e);
    end
    if (found && can) begin
      e.fresh = 1'b1;
      e.id    = IDW'(g);
      e.op    = bus.req_op[4*g +: 4];
      e.a     = bus.req_a[32*g +: 32];
      e.b     = bus.req_b[32*g +: 32];
      e.res   = alu_ref(e.op, e.a, e.b);
      exp_q.push_back(EW'(e));
      mptr = (g + 1) % NREQ;
    end
    acc = exp_ready;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_rr_ptr", 32'(rr_ptr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    exp_q.delete();
    mptr = 0;
  endtask

  logic [NREQ-1:0] acc;
  int              nacc;
  int              ndrain;
  int              prev_id;
  logic            cur_v [NREQ];

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // single ADD 5+7
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    step(acc);
    check("single_accept", 32'(acc), 32'd1);
    set_req(0, 1'b0, 4'd0, 32'd5, 32'd7);
    step(acc);
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("single_rsp_data", bus.rsp_data, 32'd12);
    step(acc);

    // round robin: req0 SUB 10-3, req1 SLT -1<1
    set_req(0, 1'b1, 4'd1, 32'd10, 32'd3);
    set_req(1, 1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1);
    prev_id = -1;
    for (int c = 0; c < 8; c++) begin
      step(acc);
      if (bus.rsp_valid) begin
        check("rr_data", bus.rsp_data, (bus.rsp_id == 0) ? 32'd7 : 32'd1);
        if (prev_id >= 0) check("rr_alternate", 32'(bus.rsp_id), 32'(prev_id ^ 1));
        prev_id = int'(bus.rsp_id);
      end
    end
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) step(acc);

    // backpressure: consumer stalls 5 cycles while req0 streams
    bus.rsp_ready = 1'b0;
    nacc = 0;
    set_req(0, 1'b1, 4'd0, 32'd100, 32'd1);
    for (int c = 0; c < 5; c++) begin
      step(acc);
      if (acc[0]) begin
        nacc++;
        set_req(0, 1'b1, 4'd0, 32'(100 + nacc), 32'd1);
      end
      if (c >= 1) check("bp_hold", bus.rsp_data, 32'd101);
    end
    check("bp_accepts", 32'(nacc), 32'd2);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    ndrain = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rsp_valid) ndrain++;
      step(acc);
    end
    check("bp_drained", 32'(ndrain), 32'd2);

    // SRA through the shared ALU
    set_req(1, 1'b1, 4'd8, 32'd4, 32'h8000_0000);
    step(acc);
    set_req(1, 1'b0, 4'd8, 32'd4, 32'h8000_0000);
    step(acc);
    check("sra_valid", 32'(bus.rsp_valid), 32'd1);
    check("sra_id", 32'(bus.rsp_id), 32'd1);
    check("sra_data", bus.rsp_data, 32'hF800_0000);
    step(acc);

    // reset with both stages full
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'd2, 32'hF0F0, 32'hFF00);
    for (int c = 0; c < 3; c++) step(acc);
    check("mid_full_valid", 32'(bus.rsp_valid), 32'd1);
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
    step(acc);
    set_req(0, 1'b0, 4'd0, 32'd1, 32'd1);
    step(acc);
    check("post_rst_valid", 32'(bus.rsp_valid), 32'd1);
    check("post_rst_data", bus.rsp_data, 32'd2);
    step(acc);

    // randomized traffic
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_v[i] || (((acc >> i) & 1) != 0)) begin
          cur_v[i] = ($urandom_range(0, 3) != 0);
          set_req(i, cur_v[i], 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step(acc);
    check("final_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
